// File: rtl/gate_tt_pkg.sv
// rtl/gate_tt_pkg.sv - state encodings and truth-table constants for the gate test sequencer
package gate_tt_pkg;

    localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
    localparam logic [2:0] ST_DRIVE_ENC  = 3'd1;
    localparam logic [2:0] ST_SETTLE_ENC = 3'd2;
    localparam logic [2:0] ST_SAMPLE_ENC = 3'd3;
    localparam logic [2:0] ST_DONE_ENC   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = ST_IDLE_ENC,
        ST_DRIVE  = ST_DRIVE_ENC,
        ST_SETTLE = ST_SETTLE_ENC,
        ST_SAMPLE = ST_SAMPLE_ENC,
        ST_DONE   = ST_DONE_ENC
    } state_t;

    // Bit i is the expected cell output for {a,b} = i.
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/settle_counter.sv
// rtl/settle_counter.sv - loadable 4-bit down-counter with a zero flag
module settle_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_dec,
    output logic       o_zero
);

    logic [3:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 4'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign o_zero = (r_count == 4'd0);

endmodule

// File: rtl/gate_test_sequencer.sv
// rtl/gate_test_sequencer.sv - exhaustive two-input cell test sequencer with truth-table checking
module gate_test_sequencer
    import gate_tt_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [3:0] TRUTH_TABLE   = TT_NOR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       dut_a,
    output logic       dut_b,
    input  logic       dut_f,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_mask
);

    localparam logic [3:0] SETTLE_LOAD = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_idx;
    logic       r_a;
    logic       r_b;
    logic       r_done;
    logic       r_pass;
    logic [2:0] r_err;
    logic [3:0] r_mask;
    logic       w_cnt_zero;
    logic       w_mismatch;

    settle_counter u_settle (
        .clk        (clk),
        .rst        (rst),
        .i_load     (r_state == ST_DRIVE),
        .i_load_val (SETTLE_LOAD),
        .i_dec      (r_state == ST_SETTLE),
        .o_zero     (w_cnt_zero)
    );

    // Case-inequality so a floating or unknown cell output counts as a failure.
    assign w_mismatch = (dut_f !== TRUTH_TABLE[r_idx]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next = ST_DRIVE;
            ST_DRIVE:  w_next = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
            ST_SETTLE: if (w_cnt_zero) w_next = ST_SAMPLE;
            ST_SAMPLE: w_next = (r_idx == 2'd3) ? ST_DONE : ST_DRIVE;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx  <= 2'd0;
            r_a    <= 1'b0;
            r_b    <= 1'b0;
            r_done <= 1'b0;
            r_pass <= 1'b0;
            r_err  <= 3'd0;
            r_mask <= 4'd0;
        end else begin
            r_done <= (r_state == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_idx  <= 2'd0;
                        r_pass <= 1'b0;
                        r_err  <= 3'd0;
                        r_mask <= 4'd0;
                    end
                end
                ST_DRIVE: begin
                    r_a <= r_idx[1];
                    r_b <= r_idx[0];
                end
                ST_SAMPLE: begin
                    if (w_mismatch) begin
                        r_mask[r_idx] <= 1'b1;
                        r_err         <= r_err + 3'd1;
                    end
                    if (r_idx != 2'd3) begin
                        r_idx <= r_idx + 2'd1;
                    end
                end
                ST_DONE: begin
                    r_pass <= (r_err == 3'd0);
                end
                default: begin
                end
            endcase
        end
    end

    assign dut_a     = r_a;
    assign dut_b     = r_b;
    assign busy      = (r_state == ST_DRIVE) || (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err;
    assign fail_mask = r_mask;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// tb/tb_gate_test_sequencer.sv - scoreboard bench for gate_test_sequencer across three configurations
module tb_gate_test_sequencer;
    import gate_tt_pkg::*;

    typedef struct {
        logic       pass;
        logic [2:0] err;
        logic [3:0] mask;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic       clk;
    logic [2:0] start_v;
    logic [2:0] rst_v;
    logic [2:0] dut_a_v;
    logic [2:0] dut_b_v;
    logic [2:0] busy_v;
    logic [2:0] done_v;
    logic [2:0] pass_v;
    logic [2:0] err_v  [3];
    logic [3:0] mask_v [3];
    logic       f0;
    logic       f1;
    logic       f2;
    logic       zf;
    int         mode;
    logic [3:0] dl;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: NOR, default settle; 1: NAND with floating output; 2: NAND, zero settle.
    gate_test_sequencer #(.SETTLE_CYCLES(2), .TRUTH_TABLE(TT_NOR)) u_nor (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .dut_a(dut_a_v[0]), .dut_b(dut_b_v[0]),
        .dut_f(f0), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .err_count(err_v[0]), .fail_mask(mask_v[0]));

    gate_test_sequencer #(.SETTLE_CYCLES(2), .TRUTH_TABLE(TT_NAND)) u_float (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .dut_a(dut_a_v[1]), .dut_b(dut_b_v[1]),
        .dut_f(f1), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .err_count(err_v[1]), .fail_mask(mask_v[1]));

    gate_test_sequencer #(.SETTLE_CYCLES(0), .TRUTH_TABLE(TT_NAND)) u_fast (
        .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .dut_a(dut_a_v[2]), .dut_b(dut_b_v[2]),
        .dut_f(f2), .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
        .err_count(err_v[2]), .fail_mask(mask_v[2]));

    always @(posedge clk) dl <= {dl[2:0], ~(dut_a_v[0] | dut_b_v[0])};

    always_comb begin
        f0 = 1'b0;
        case (mode)
            0:       f0 = ~(dut_a_v[0] | dut_b_v[0]);
            1:       f0 = 1'b1;
            2:       f0 = dl[0];
            default: f0 = dl[3];
        endcase
    end

    assign f1 = zf;
    assign f2 = ~(dut_a_v[2] & dut_b_v[2]);

    task automatic pulse_start(input int sel);
        @(negedge clk);
        start_v[sel] = 1'b1;
        @(negedge clk);
        start_v[sel] = 1'b0;
    endtask

    task automatic pulse_reset(input int sel);
        @(negedge clk);
        rst_v[sel] = 1'b1;
        @(negedge clk);
        rst_v[sel] = 1'b0;
    endtask

    task automatic wait_done(input int sel, input int budget, output int lat);
        lat = -1;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (done_v[sel] === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_v = 3'b111;
        repeat (2) @(negedge clk);
        rst_v = 3'b000;
        for (int s = 0; s < 3; s++) begin
            checks++;
            if ({dut_a_v[s], dut_b_v[s], busy_v[s], done_v[s], pass_v[s]} !== 5'b0 ||
                err_v[s] !== 3'd0 || mask_v[s] !== 4'd0) begin
                errors++;
                $display("FAIL reset_state inst %0d: a=%b b=%b busy=%b done=%b pass=%b err=%0d mask=%b required all zero",
                         s, dut_a_v[s], dut_b_v[s], busy_v[s], done_v[s], pass_v[s], err_v[s], mask_v[s]);
            end
        end
    endtask

    task automatic test_ideal_nor();
        exp_t e;
        int   lat;
        mode = 0;
        sb.push_back('{pass: 1'b1, err: 3'd0, mask: 4'b0000, lat: 17});
        pulse_start(0);
        checks++;
        if (busy_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL nor_busy_rise: got %b required 1", busy_v[0]);
        end
        wait_done(0, 40, lat);
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat || pass_v[0] !== e.pass || err_v[0] !== e.err || mask_v[0] !== e.mask) begin
            errors++;
            $display("FAIL nor_ideal: lat=%0d pass=%b err=%0d mask=%b required lat=%0d pass=%b err=%0d mask=%b",
                     lat, pass_v[0], err_v[0], mask_v[0], e.lat, e.pass, e.err, e.mask);
        end
        checks++;
        if (busy_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL nor_busy_at_done: got %b required 0", busy_v[0]);
        end
        @(negedge clk);
        checks++;
        if (done_v[0] !== 1'b0 || dut_a_v[0] !== 1'b1 || dut_b_v[0] !== 1'b1 || pass_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL nor_after_done: done=%b a=%b b=%b pass=%b required done=0 a=1 b=1 pass=1",
                     done_v[0], dut_a_v[0], dut_b_v[0], pass_v[0]);
        end
    endtask

    task automatic test_stuck_one();
        exp_t e;
        int   lat;
        mode = 1;
        sb.push_back('{pass: 1'b0, err: 3'd3, mask: 4'b1110, lat: 17});
        pulse_start(0);
        wait_done(0, 40, lat);
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat || pass_v[0] !== e.pass || err_v[0] !== e.err || mask_v[0] !== e.mask) begin
            errors++;
            $display("FAIL stuck_one: lat=%0d pass=%b err=%0d mask=%b required lat=%0d pass=%b err=%0d mask=%b",
                     lat, pass_v[0], err_v[0], mask_v[0], e.lat, e.pass, e.err, e.mask);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (err_v[0] !== 3'd3 || mask_v[0] !== 4'b1110 || pass_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL stuck_one_hold: err=%0d mask=%b pass=%b required err=3 mask=1110 pass=0",
                     err_v[0], mask_v[0], pass_v[0]);
        end
    endtask

    task automatic test_float_nand();
        exp_t       e;
        int         lat;
        logic [3:0] tt;
        logic [3:0] m;
        logic [2:0] cnt;
        tt  = TT_NAND;
        m   = 4'b0000;
        cnt = 3'd0;
        for (int i = 0; i < 4; i++) begin
            m[i] = (zf !== tt[i]);
            if (m[i]) cnt = cnt + 3'd1;
        end
        sb.push_back('{pass: (cnt == 3'd0), err: cnt, mask: m, lat: 17});
        pulse_start(1);
        wait_done(1, 40, lat);
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat || pass_v[1] !== e.pass || err_v[1] !== e.err || mask_v[1] !== e.mask) begin
            errors++;
            $display("FAIL float_nand: lat=%0d pass=%b err=%0d mask=%b required lat=%0d pass=%b err=%0d mask=%b",
                     lat, pass_v[1], err_v[1], mask_v[1], e.lat, e.pass, e.err, e.mask);
        end
    endtask

    task automatic test_zero_settle_restart();
        exp_t e;
        int   first;
        int   pulses;
        first  = -1;
        pulses = 0;
        sb.push_back('{pass: 1'b1, err: 3'd0, mask: 4'b0000, lat: 9});
        pulse_start(2);
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            if (done_v[2] === 1'b1) begin
                pulses++;
                if (first < 0) begin
                    first = n;
                    e = sb.pop_front();
                    checks++;
                    if (pass_v[2] !== e.pass || err_v[2] !== e.err || mask_v[2] !== e.mask) begin
                        errors++;
                        $display("FAIL zero_settle: pass=%b err=%0d mask=%b required pass=%b err=%0d mask=%b",
                                 pass_v[2], err_v[2], mask_v[2], e.pass, e.err, e.mask);
                    end
                    checks++;
                    if (first !== e.lat) begin
                        errors++;
                        $display("FAIL zero_settle_latency: got %0d required %0d", first, e.lat);
                    end
                end
            end
            start_v[2] = (n >= 1 && n <= 3) || (n == 8);
        end
        start_v[2] = 1'b0;
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL busy_restart_pulses: got %0d required 1", pulses);
        end
    endtask

    task automatic test_reset_mid_run();
        exp_t e;
        int   lat;
        mode = 0;
        pulse_start(0);
        repeat (9) @(negedge clk);
        checks++;
        if (busy_v[0] !== 1'b1 || dut_a_v[0] !== 1'b1 || dut_b_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_run_vector2: busy=%b a=%b b=%b required busy=1 a=1 b=0",
                     busy_v[0], dut_a_v[0], dut_b_v[0]);
        end
        rst_v[0] = 1'b1;
        @(negedge clk);
        rst_v[0] = 1'b0;
        checks++;
        if ({dut_a_v[0], dut_b_v[0], busy_v[0], done_v[0], pass_v[0]} !== 5'b0 ||
            err_v[0] !== 3'd0 || mask_v[0] !== 4'd0) begin
            errors++;
            $display("FAIL mid_run_reset: a=%b b=%b busy=%b done=%b pass=%b err=%0d mask=%b required all zero",
                     dut_a_v[0], dut_b_v[0], busy_v[0], done_v[0], pass_v[0], err_v[0], mask_v[0]);
        end
        sb.push_back('{pass: 1'b1, err: 3'd0, mask: 4'b0000, lat: 17});
        pulse_start(0);
        wait_done(0, 40, lat);
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat || pass_v[0] !== e.pass || err_v[0] !== e.err || mask_v[0] !== e.mask) begin
            errors++;
            $display("FAIL after_reset_run: lat=%0d pass=%b err=%0d mask=%b required lat=%0d pass=%b err=%0d mask=%b",
                     lat, pass_v[0], err_v[0], mask_v[0], e.lat, e.pass, e.err, e.mask);
        end
    endtask

    task automatic test_transport_delay();
        exp_t e;
        int   lat;
        mode = 2;
        sb.push_back('{pass: 1'b1, err: 3'd0, mask: 4'b0000, lat: 17});
        pulse_start(0);
        wait_done(0, 40, lat);
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat || pass_v[0] !== e.pass || err_v[0] !== e.err || mask_v[0] !== e.mask) begin
            errors++;
            $display("FAIL delay1: lat=%0d pass=%b err=%0d mask=%b required lat=%0d pass=%b err=%0d mask=%b",
                     lat, pass_v[0], err_v[0], mask_v[0], e.lat, e.pass, e.err, e.mask);
        end
        // From reset the inputs sit at 00, so with a 4-cycle delay each vector
        // sees the previous vector's response; only vector 1 then disagrees.
        pulse_reset(0);
        mode = 3;
        repeat (6) @(negedge clk);
        sb.push_back('{pass: 1'b0, err: 3'd1, mask: 4'b0010, lat: 17});
        pulse_start(0);
        wait_done(0, 40, lat);
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat || pass_v[0] !== e.pass || err_v[0] !== e.err || mask_v[0] !== e.mask) begin
            errors++;
            $display("FAIL delay4: lat=%0d pass=%b err=%0d mask=%b required lat=%0d pass=%b err=%0d mask=%b",
                     lat, pass_v[0], err_v[0], mask_v[0], e.lat, e.pass, e.err, e.mask);
        end
    endtask

    initial begin
        start_v = 3'b000;
        rst_v   = 3'b111;
        mode    = 0;
        zf      = 1'bz;
        test_reset();
        test_ideal_nor();
        test_stuck_one();
        test_float_nand();
        test_zero_settle_restart();
        test_reset_mid_run();
        test_transport_delay();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
